// File: rtl/frame_l2_in.sv
// -----------------------------------------------------------------------------
// frame_l2_in
// Receive side of the L2 nibble link. Takes the link after DDR input capture,
// strips preamble/SFD, assembles bytes, checks the Ethernet CRC32, removes the
// 4-byte FCS and hands the payload to the L2 frame dispatcher as a byte stream
// with a per-frame error flag.
//
// Ports:
//   Clk       system clock, also the DDR capture clock
//   nRst      asynchronous active-low reset
//   MODE      0 = one nibble per Clk, 1 = one byte per Clk (both edges)
//   RxVal     link valid
//   RxDataL   nibble from the rising-edge phase (high nibble in MODE 1)
//   RxDataH   nibble from the falling-edge phase (MODE 1 only)
//   ValOut    single-cycle byte strobe
//   SoFOut    first payload byte of a frame (qualified by ValOut)
//   EoFOut    last payload byte of a frame (qualified by ValOut)
//   DataOut   payload byte
//   ErrOut    frame error, valid with ValOut & EoFOut
//   FrameCnt  good frames delivered (wraps)
//   ErrCnt    errored, truncated or runt frames (wraps)
// -----------------------------------------------------------------------------
module frame_l2_in #(
  parameter int MAX_BYTES = 1522,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             MODE,
  input  logic             RxVal,
  input  logic [3:0]       RxDataL,
  input  logic [3:0]       RxDataH,
  output logic             ValOut,
  output logic             SoFOut,
  output logic             EoFOut,
  output logic [7:0]       DataOut,
  output logic             ErrOut,
  output logic [CNT_W-1:0] FrameCnt,
  output logic [CNT_W-1:0] ErrCnt
);

  localparam int          BCNT_W        = $clog2(MAX_BYTES + 1);
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  // Residue is quoted in normal bit order; the register runs reflected.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam int          FCS_DEPTH     = 5;  // hold stage + 4 FCS stages

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} stateT;

  function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] bitRev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  stateT             stateQ, stateD;
  logic              sawDQ;        // MODE 0: SFD high nibble seen, expecting 5
  logic              nibPhaseQ;    // MODE 0: high nibble of current byte held
  logic [3:0]        hiNibQ;
  logic [BCNT_W-1:0] byteCntQ;     // bytes after SFD, FCS included
  logic [31:0]       crcQ;
  logic              firstOutQ;    // next emitted byte is the first payload byte
  logic [7:0]        dlyQ [FCS_DEPTH];

  // Emission stage: decided on the assembly Clk, presented on the next one.
  logic              emitValQ, emitSofQ, emitEofQ, emitErrQ;
  logic [7:0]        emitDataQ;

  logic [7:0]        pairByte, rxByte;
  logic              isPre, enterData, setSawD;
  logic              byteStrobe, frameEnd, lastByte;
  logic              emitNow, endEmit, runt;
  logic              crcGood;

  assign crcGood = (bitRev32(crcQ) == CRC_RESIDUE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) stateQ <= DROP;  // a frame in flight at reset release is discarded
    else       stateQ <= stateD;
  end

  // ---------------------------------------------------------------------------
  // FSM: decode / control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pairByte   = {RxDataL, RxDataH};
    rxByte     = MODE ? pairByte : {hiNibQ, RxDataL};
    isPre      = MODE ? (pairByte == 8'h55) : (RxDataL == 4'h5);
    enterData  = 1'b0;
    setSawD    = 1'b0;
    byteStrobe = 1'b0;
    frameEnd   = 1'b0;
    unique case (stateQ)
      PREAMBLE: begin
        if (RxVal) begin
          if (MODE) begin
            enterData = (pairByte == 8'hD5);
          end else begin
            enterData = sawDQ && (RxDataL == 4'h5);
            setSawD   = !sawDQ && (RxDataL == 4'hD);
          end
        end
      end
      DATA: begin
        byteStrobe = RxVal && (MODE || nibPhaseQ);
        frameEnd   = !RxVal;
      end
      default: ;
    endcase
    lastByte = byteStrobe && (byteCntQ == BCNT_W'(MAX_BYTES - 1));
    emitNow  = byteStrobe && (byteCntQ >= BCNT_W'(FCS_DEPTH));
    endEmit  = frameEnd && (byteCntQ >= BCNT_W'(FCS_DEPTH));
    runt     = frameEnd && (byteCntQ <  BCNT_W'(FCS_DEPTH));
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:     if (RxVal) stateD = isPre ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!RxVal)                                stateD = IDLE;
        else if (enterData)                        stateD = DATA;
        else if (!(isPre && !sawDQ) && !setSawD)   stateD = DROP;
      end
      DATA: begin
        if (frameEnd)      stateD = IDLE;
        else if (lastByte) stateD = DROP;  // truncated; rest of frame ignored
      end
      DROP:     if (!RxVal) stateD = IDLE;
      default:  stateD = DROP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte assembly, byte count and CRC
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      sawDQ     <= 1'b0;
      nibPhaseQ <= 1'b0;
      hiNibQ    <= '0;
      byteCntQ  <= '0;
      crcQ      <= '1;
      firstOutQ <= 1'b0;
    end else begin
      sawDQ <= setSawD;
      if (enterData) begin
        nibPhaseQ <= 1'b0;
        byteCntQ  <= '0;
        crcQ      <= '1;
        firstOutQ <= 1'b1;
      end else if (stateQ == DATA && RxVal) begin
        if (!MODE) begin
          nibPhaseQ <= !nibPhaseQ;
          if (!nibPhaseQ) hiNibQ <= RxDataL;
        end
        if (byteStrobe) begin
          byteCntQ <= byteCntQ + BCNT_W'(1);
          crcQ     <= crcByte(crcQ, rxByte);
        end
        if (emitNow) firstOutQ <= 1'b0;
      end
    end
  end

  // NOTE: the delay line holds only data; its contents are never observed
  // before being filled, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (byteStrobe) begin
      dlyQ[0] <= rxByte;
      for (int i = 1; i < FCS_DEPTH; i++) dlyQ[i] <= dlyQ[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Emission stage and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      emitValQ  <= 1'b0;
      emitSofQ  <= 1'b0;
      emitEofQ  <= 1'b0;
      emitErrQ  <= 1'b0;
      emitDataQ <= '0;
    end else begin
      emitValQ <= emitNow || endEmit;
      emitSofQ <= firstOutQ;
      emitEofQ <= endEmit || lastByte;
      // Frame end: CRC residue or a dangling nibble; truncation is always an error.
      emitErrQ <= endEmit ? (!crcGood || (!MODE && nibPhaseQ)) : lastByte;
      if (emitNow || endEmit) emitDataQ <= dlyQ[FCS_DEPTH-1];
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      ValOut   <= 1'b0;
      SoFOut   <= 1'b0;
      EoFOut   <= 1'b0;
      ErrOut   <= 1'b0;
      DataOut  <= '0;
      FrameCnt <= '0;
      ErrCnt   <= '0;
    end else begin
      ValOut <= emitValQ;
      SoFOut <= emitValQ && emitSofQ;
      EoFOut <= emitValQ && emitEofQ;
      ErrOut <= emitValQ && emitEofQ && emitErrQ;
      if (emitValQ) DataOut <= emitDataQ;
      if (emitValQ && emitEofQ && !emitErrQ) FrameCnt <= FrameCnt + CNT_W'(1);
      ErrCnt <= ErrCnt + CNT_W'(emitValQ && emitEofQ && emitErrQ) + CNT_W'(runt);
    end
  end

endmodule
